// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for a filtered lock,
// releases the PLL-domain reset and retries or fails on missing lock.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int CMAX_A = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT) ? CMAX_A : LOCK_TIMEOUT;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [3:0]      retry_n;
    logic [3:0]      retry_inc;
    logic [7:0]      loss_n;
    logic            lk_meta;
    logic            lk_s;

    assign retry_inc = retry_cnt + 4'd1;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lk_meta       <= 1'b0;
            lk_s          <= 1'b0;
            cur           <= RST_PLL;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            lk_meta       <= pll_locked;
            lk_s          <= lk_meta;
            cur           <= nxt;
            cnt           <= cnt_n;
            retry_cnt     <= retry_n;
            lock_loss_cnt <= loss_n;
        end
    end

    // restart outranks every other transition, including loss-of-lock in RUN
    always_comb begin
        nxt     = cur;
        cnt_n   = cnt + CW'(1);
        retry_n = retry_cnt;
        loss_n  = lock_loss_cnt;
        if (restart) begin
            nxt     = RST_PLL;
            cnt_n   = '0;
            retry_n = '0;
        end else begin
            case (cur)
                RST_PLL: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        nxt   = WAIT_LOCK;
                        cnt_n = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        nxt   = FILTER;
                        cnt_n = '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        retry_n = retry_inc;
                        nxt     = (retry_inc == 4'(MAX_RETRY)) ? FAIL : RST_PLL;
                        cnt_n   = '0;
                    end
                end
                FILTER: begin
                    if (!lk_s) begin
                        nxt   = WAIT_LOCK;
                        cnt_n = '0;
                    end else if (cnt == CW'(LOCK_FILTER - 1)) begin
                        nxt     = RUN;
                        retry_n = '0;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    cnt_n = '0;
                    if (!lk_s) begin
                        nxt    = RST_PLL;
                        loss_n = (lock_loss_cnt != 8'hFF) ?
                                 lock_loss_cnt + 8'd1 : lock_loss_cnt;
                    end
                end
                FAIL: begin
                    cnt_n = '0;
                end
                default: begin
                    nxt   = RST_PLL;
                    cnt_n = '0;
                end
            endcase
        end
    end

    assign state     = cur;
    assign pll_rst   = (cur == RST_PLL) || (cur == FAIL);
    assign sys_rst_n = (cur == RUN);
    assign fail      = (cur == FAIL);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues timed
// expectations, a negedge monitor pops and compares them.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_lock_sequencer dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .fail          (fail),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    typedef struct {
        string      name;
        int         at;
        logic [2:0] st;
        logic [3:0] retry;
        logic [7:0] loss;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic push_exp(input string nm, input int at, input logic [2:0] st,
                            input logic [3:0] r, input logic [7:0] l);
        exp_t e;
        e.name  = nm;
        e.at    = at;
        e.st    = st;
        e.retry = r;
        e.loss  = l;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Moore output table: pll_rst in RST_PLL/FAIL, sys_rst_n in RUN, fail in FAIL
    always @(negedge refclk) begin
        exp_t        e;
        logic [17:0] act;
        logic [17:0] req;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e   = q.pop_front();
            act = {pll_rst, sys_rst_n, fail, state, retry_cnt, lock_loss_cnt};
            req = {(e.st == 3'd0 || e.st == 3'd4), (e.st == 3'd3),
                   (e.st == 3'd4), e.st, e.retry, e.loss};
            tests++;
            if (e.at != cyc || act !== req) begin
                fails++;
                $display("FAIL %s cyc=%0d(due %0d): got st=%0d prst=%b srst_n=%b fail=%b retry=%0d loss=%0d, want st=%0d prst=%b srst_n=%b fail=%b retry=%0d loss=%0d",
                         e.name, cyc, e.at, state, pll_rst, sys_rst_n, fail,
                         retry_cnt, lock_loss_cnt, e.st, req[17], req[16],
                         req[15], e.retry, e.loss);
            end
        end
    end

    initial begin
        int b;
        int b2;
        int b3;
        int b4;
        int b5;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        step(3);
        push_exp("reset", cyc, 3'd0, 4'd0, 8'd0);

        // nominal lock 100 cycles after release
        b = cyc;
        rst_n = 1'b1;
        push_exp("rst_pll_last", b + 15, 3'd0, 4'd0, 8'd0);
        push_exp("wait_entry", b + 16, 3'd1, 4'd0, 8'd0);
        push_exp("sync_wait", b + 102, 3'd1, 4'd0, 8'd0);
        push_exp("filter_entry", b + 103, 3'd2, 4'd0, 8'd0);
        push_exp("filter_last", b + 166, 3'd2, 4'd0, 8'd0);
        push_exp("run_at_67", b + 167, 3'd3, 4'd0, 8'd0);
        step(100);
        pll_locked = 1'b1;
        step(70);

        // loss of lock in RUN, relock with a one-cycle glitch in FILTER
        b2 = cyc;
        push_exp("loss_sync", b2 + 2, 3'd3, 4'd0, 8'd0);
        push_exp("loss_rst", b2 + 3, 3'd0, 4'd0, 8'd1);
        push_exp("relock_wait", b2 + 19, 3'd1, 4'd0, 8'd1);
        push_exp("relock_filter", b2 + 20, 3'd2, 4'd0, 8'd1);
        push_exp("glitch_sync", b2 + 51, 3'd2, 4'd0, 8'd1);
        push_exp("glitch_wait", b2 + 52, 3'd1, 4'd0, 8'd1);
        push_exp("glitch_refilter", b2 + 53, 3'd2, 4'd0, 8'd1);
        push_exp("glitch_filter_last", b2 + 116, 3'd2, 4'd0, 8'd1);
        push_exp("glitch_run", b2 + 117, 3'd3, 4'd0, 8'd1);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        step(46);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(71);

        // restart coincident with lock drop in RUN
        b3 = cyc;
        push_exp("rs_pre", b3 + 2, 3'd3, 4'd0, 8'd1);
        push_exp("rs_noinc", b3 + 3, 3'd0, 4'd0, 8'd1);
        push_exp("rs_relock", b3 + 84, 3'd3, 4'd0, 8'd1);
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart    = 1'b0;
        pll_locked = 1'b1;
        step(87);

        // 300 forced losses saturate the loss counter
        for (int i = 0; i < 300; i++) begin
            if (i == 99)
                push_exp("loss_101", cyc + 3, 3'd0, 4'd0, 8'd101);
            if (i == 253)
                push_exp("loss_255", cyc + 3, 3'd0, 4'd0, 8'd255);
            if (i == 254)
                push_exp("loss_sat", cyc + 3, 3'd0, 4'd0, 8'd255);
            if (i == 299)
                push_exp("loss_sat_end", cyc + 3, 3'd0, 4'd0, 8'd255);
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(87);
        end
        push_exp("sat_run", cyc, 3'd3, 4'd0, 8'd255);

        // reset at WAIT_LOCK count 2000, then never lock
        b4 = cyc;
        push_exp("mid_wait", b4 + 2019, 3'd1, 4'd0, 8'd255);
        push_exp("mid_reset", b4 + 2020, 3'd0, 4'd0, 8'd0);
        push_exp("mid_rst_last", b4 + 2035, 3'd0, 4'd0, 8'd0);
        push_exp("mid_wait_entry", b4 + 2036, 3'd1, 4'd0, 8'd0);
        pll_locked = 1'b0;
        step(2019);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        b5 = cyc;
        push_exp("to1_last", b5 + 4111, 3'd1, 4'd0, 8'd0);
        push_exp("to1_retry", b5 + 4112, 3'd0, 4'd1, 8'd0);
        push_exp("to1_wait", b5 + 4128, 3'd1, 4'd1, 8'd0);
        push_exp("to2_retry", b5 + 8224, 3'd0, 4'd2, 8'd0);
        push_exp("to3_last", b5 + 12335, 3'd1, 4'd2, 8'd0);
        push_exp("fail_entry", b5 + 12336, 3'd4, 4'd3, 8'd0);
        push_exp("fail_hold", b5 + 12400, 3'd4, 4'd3, 8'd0);
        push_exp("fail_restart", b5 + 12401, 3'd0, 4'd0, 8'd0);
        step(12400);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(5);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL provide parameter RST_CYCLES, default 16: number of cycles the PLL reset is held per attempt (>=1).
REQ-002 SHALL provide parameter LOCK_FILTER, default 64: consecutive synchronized-lock cycles required before release (>=1).
REQ-003 SHALL provide parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK without lock before a retry (>=1).
REQ-004 SHALL provide parameter MAX_RETRY, default 3: number of failed lock attempts that forces FAIL (1..15).
REQ-005 refclk  input  1  single free-running clock; all flops on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on refclk.
REQ-007 pll_locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 restart  input  1  single-cycle request to re-run the full sequence.
REQ-009 pll_rst  output  1  active-high reset to the PLL.
REQ-010 sys_rst_n  output  1  active-low reset for the logic clocked by the PLL output.
REQ-011 fail  output  1  high while in FAIL.
REQ-012 state  output  3  current state encoding.
REQ-013 retry_cnt  output  4  failed attempts since the last RUN entry or restart.
REQ-014 lock_loss_cnt  output  8  loss-of-lock events seen in RUN, saturating.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lk_s (2nd stage) is the only lock signal used by the FSM.
REQ-016 States and encodings SHALL be RST_PLL=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAIL=4; codes 5-7 SHALL go to RST_PLL on the next cycle.
REQ-017 Outputs SHALL be Moore-decoded from the state register: pll_rst=1 in RST_PLL or FAIL; sys_rst_n=1 only in RUN; fail=1 only in FAIL.
REQ-018 RST_PLL SHALL last exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-019 WAIT_LOCK with lk_s=1 SHALL go to FILTER with the filter counter cleared.
REQ-020 WAIT_LOCK with lk_s=0 for LOCK_TIMEOUT cycles SHALL increment retry_cnt, then go to FAIL if the new value equals MAX_RETRY, else to RST_PLL.
REQ-021 FILTER SHALL go to RUN after LOCK_FILTER consecutive cycles with lk_s=1.
REQ-022 Any lk_s=0 cycle in FILTER SHALL return the FSM to WAIT_LOCK with the timeout counter cleared; retry_cnt is unchanged.
REQ-023 Entry to RUN SHALL clear retry_cnt.
REQ-024 lk_s=0 in RUN SHALL increment lock_loss_cnt (saturating at 255) and go to RST_PLL.
REQ-025 FAIL SHALL be exited only by restart or rst_n.
REQ-026 restart=1 in any state SHALL go to RST_PLL with the cycle counter and retry_cnt cleared.
REQ-027 restart SHALL take priority over every other transition; restart coincident with lk_s=0 in RUN SHALL NOT increment lock_loss_cnt.
REQ-028 A single cycle counter sized for max(RST_CYCLES, LOCK_FILTER, LOCK_TIMEOUT) SHALL be shared by RST_PLL, WAIT_LOCK and FILTER and cleared on every state change.

Reset
REQ-029 While rst_n=0 at a rising edge, all of the following SHALL hold from the next edge: state=RST_PLL, pll_rst=1, sys_rst_n=0, fail=0, retry_cnt=0, lock_loss_cnt=0, counters=0, synchronizer flops=0.
REQ-030 The first rst_n=1 cycle SHALL begin a full RST_CYCLES count.
REQ-031 Reset asserted in any state, mid-count, SHALL override all other inputs.

Verification
REQ-032 Nominal: default parameters; pll_locked rises 100 cycles after rst_n release and stays high. Required: pll_rst high for the first 16 cycles; sys_rst_n rises exactly 67 cycles after pll_locked rises; retry_cnt=0.
REQ-033 Never locks: pll_locked held at 0. Required: three pll_rst pulses of 16 cycles; state=4 and fail=1 after 3*(16+4096) cycles; retry_cnt=3; sys_rst_n stays 0.
REQ-034 Filter glitch: pll_locked dropped for 1 cycle 30 cycles into FILTER. Required: state returns to 1; RUN is entered only after 64 further clean cycles; retry_cnt unchanged.
REQ-035 Loss of lock in RUN: pll_locked falls. Required: sys_rst_n=0 and pll_rst=1 within 3 cycles; lock_loss_cnt=1; normal relock follows. After 300 forced losses, lock_loss_cnt=255.
REQ-036 restart: restart pulsed in FAIL. Required: state=0, fail=0, retry_cnt=0 next cycle. restart coincident with a lock drop in RUN. Required: lock_loss_cnt unchanged.
REQ-037 Mid-operation reset: rst_n=0 for 1 cycle during WAIT_LOCK at count 2000. Required: all REQ-029 values, then a fresh 16-cycle pll_rst pulse.
